// File: rtl/pixel_writer_pkg.sv
// Shared types for the pixel frame writer: controller states and the
// word record that travels through the write FIFO.
package pixel_writer_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_ADDR_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0]    addr;
        logic [31:0]               data;
        logic [BYTES_PER_WORD-1:0] strb;
    } wr_word_t;

endpackage

// File: rtl/word_fifo.sv
// Show-ahead FIFO of wr_word_t: the head entry is visible whenever not empty.
// A pop in the same cycle frees a slot for a push even when full.
module word_fifo
    import pixel_writer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  wr_word_t i_push_word,
    input  logic     i_pop,
    output wr_word_t o_head,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    wr_word_t       r_mem [DEPTH];
    logic           w_do_push;
    logic           w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_word;
    end

endmodule

// File: rtl/pixel_frame_writer.sv
// Captures one frame of streamed 8-bit pixels, packs them little-endian into
// 32-bit words and writes them to consecutive word addresses via a FIFO.
module pixel_frame_writer
    import pixel_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [11:0]       size_x,
    input  logic [11:0]       size_y,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        pixel_in,
    input  logic              pixel_valid,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    state_t            r_state;
    logic [23:0]       r_total;
    logic [ADDR_W-1:0] r_base;
    logic [23:0]       r_pix_cnt;
    logic [21:0]       r_word_idx;
    logic [31:0]       r_pack_data;
    logic [3:0]        r_pack_strb;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;

    logic [23:0]       w_total_in;
    logic [1:0]        w_lane;
    logic              w_accept;
    logic              w_last;
    logic              w_complete;
    logic [31:0]       w_word_data;
    logic [3:0]        w_word_strb;
    logic [ADDR_W-1:0] w_word_addr;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_fifo_push;
    logic              w_drop;
    wr_word_t          w_push_word;
    wr_word_t          w_head;
    logic              w_unused_base_lsbs;

    assign w_unused_base_lsbs = ^base_addr[1:0];

    assign w_total_in  = {12'd0, size_x} * {12'd0, size_y};
    assign w_lane      = r_pix_cnt[1:0];
    assign w_accept    = (r_state == RUN) && pixel_valid;
    assign w_last      = (r_pix_cnt == r_total - 24'd1);
    assign w_complete  = w_accept && ((w_lane == 2'd3) || w_last);
    assign w_word_data = r_pack_data | ({24'd0, pixel_in} << {w_lane, 3'b000});
    assign w_word_strb = r_pack_strb | (4'b0001 << w_lane);
    assign w_word_addr = r_base + ADDR_W'({r_word_idx, 2'b00});

    assign w_pop       = !w_empty && wr_ready;
    assign w_fifo_push = w_complete && (!w_full || w_pop);
    assign w_drop      = w_complete && w_full && !w_pop;

    assign w_push_word.addr = WORD_ADDR_W'(w_word_addr);
    assign w_push_word.data = w_word_data;
    assign w_push_word.strb = w_word_strb;

    word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_fifo_push),
        .i_push_word(w_push_word),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Head is masked to zero while empty so the port idles at its reset values.
    assign wr_valid = !w_empty;
    assign wr_addr  = w_empty ? '0 : w_head.addr[ADDR_W-1:0];
    assign wr_data  = w_empty ? '0 : w_head.data;
    assign wr_strb  = w_empty ? '0 : w_head.strb;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_total     <= '0;
            r_base      <= '0;
            r_pix_cnt   <= '0;
            r_word_idx  <= '0;
            r_pack_data <= '0;
            r_pack_strb <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_total     <= w_total_in;
                        r_base      <= {base_addr[ADDR_W-1:2], 2'b00};
                        r_pix_cnt   <= '0;
                        r_word_idx  <= '0;
                        r_pack_data <= '0;
                        r_pack_strb <= '0;
                        r_overflow  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (w_total_in == 24'd0) ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_pix_cnt <= r_pix_cnt + 24'd1;
                        if (w_complete) begin
                            r_word_idx  <= r_word_idx + 22'd1;
                            r_pack_data <= '0;
                            r_pack_strb <= '0;
                        end else begin
                            r_pack_data <= w_word_data;
                            r_pack_strb <= w_word_strb;
                        end
                        if (w_drop) r_overflow <= 1'b1;
                        if (w_last) r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (w_empty) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pixel_frame_writer.md
Name: pixel_frame_writer

Overview:
Sink for the filter's streaming output (pixel_out/pixel_valid of the top-level DUT). It counts the pixels of one frame, packs bytes into 32-bit little-endian words, and buffers them in a small FIFO. It then writes the words to a memory port over a valid/ready handshake at consecutive word addresses from a base address. It signals completion with a one-cycle done pulse and flags data lost to back-pressure.

Parameters:
FIFO_DEPTH, 8, word FIFO depth (power of two, >= 2)
ADDR_W, 32, width of base_addr and wr_addr

Ports:
clk  in  1  core clock
rst  in  1  system reset
start  in  1  begin frame capture (pulse, honoured only in IDLE)
size_x  in  12  image width in pixels
size_y  in  12  image height in pixels
base_addr  in  ADDR_W  byte address of first word (bits [1:0] ignored, treated as 0)
pixel_in  in  8  streaming pixel from the filter
pixel_valid  in  1  pixel_in valid this cycle
wr_valid  out  1  write request valid
wr_ready  in  1  memory accepts the request this cycle
wr_addr  out  ADDR_W  byte address of the word
wr_data  out  32  packed pixels; first pixel of the word in [7:0]
wr_strb  out  4  byte enables
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse: frame fully written
overflow  out  1  sticky: at least one word dropped because the FIFO was full

Behaviour:
- Clocking/reset: single clock clk. Reset rst is asynchronous and active-high.
- On reset: state IDLE; FIFO emptied; counters and packer cleared; wr_valid=0, wr_addr=0, wr_data=0, wr_strb=0, busy=0, done=0, overflow=0.
- State IDLE:
  - start=1: latch size_x, size_y and base_addr; total = size_x*size_y (24-bit unsigned, max 16 769 025).
  - Clear pix_cnt (24 b) and word_idx (22 b); clear overflow.
  - Go to RUN, or to FLUSH if total==0.
  - pixel_valid is ignored in IDLE.
- State RUN:
  - Each pixel_valid cycle stores pixel_in in byte lane pix_cnt[1:0] and increments pix_cnt.
  - A word completes when lane 3 is written or the pixel is the last one (pix_cnt==total-1).
  - On completion: push {addr = base + 4*word_idx, data, strb} on the next clock edge; increment word_idx; clear the packer.
  - Partial last word: strb has ones for the filled lanes only (e.g. 1 pixel -> 4'b0001); unfilled data bytes are 0.
  - Last pixel accepted: go to FLUSH. pixel_valid after the last pixel, in FLUSH or in DONE, is ignored.
- FIFO full at the push edge: the word is dropped, word_idx still increments so later addresses stay correct, and overflow is set. overflow holds until the next accepted start or reset.
- State FLUSH: wait until the FIFO is empty and no write is outstanding, then go to DONE.
- State DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, FLUSH and DONE.
- Write port:
  - The FIFO head is presented on wr_valid/wr_addr/wr_data/wr_strb.
  - A word is transferred on a cycle with wr_valid & wr_ready. The next word may be presented in the following cycle, sustaining one word per cycle.
  - Once wr_valid=1, it and its data stay stable until accepted. wr_valid never drops without a handshake, except on reset.
- Latency: the pixel completing a word at cycle N gives FIFO push at edge N+1 and earliest wr_valid in cycle N+1 when the FIFO was empty.
- start while busy: ignored.
- Simultaneous FIFO push and pop in the same cycle is allowed, including when full; a pop frees a slot for the same-edge push.
- Address arithmetic wraps modulo 2^ADDR_W.
- rst mid-frame: everything returns to the reset values immediately. A request in flight is abandoned.

Decomposition:
- Package pixel_writer_pkg:
  - state enum {IDLE, RUN, FLUSH, DONE}
  - struct wr_word_t {addr, data[31:0], strb[3:0]}
  - constant BYTES_PER_WORD=4
- One sub-module, word_fifo: synchronous show-ahead FIFO of wr_word_t, depth FIFO_DEPTH, with full/empty flags.

Test Plan:
- 4x2 frame, base 0x1000, pixels 0x10..0x17 on consecutive cycles, wr_ready=1 -> writes (0x1000, 0x13121110, F) and (0x1004, 0x17161514, F); one done pulse; overflow=0.
- 3x1 frame, pixels 0x20,0x21,0x22 -> single write (base, 0x00222120, 4'b0111); then done.
- 4x4 frame, wr_ready=0 for 30 cycles then 1 -> 4 writes in order at base+0/4/8/C; wr_valid and data held stable while stalled; no overflow.
- 8x8 frame, FIFO_DEPTH=8, wr_ready=0 throughout capture then 1 -> 8 words written, words 9..16 dropped, overflow=1 after done; next start clears it.
- size_x=0, start -> no write; done pulses exactly once within 3 cycles; busy returns to 0.
- rst asserted after 5 pixels of a 4x4 frame, then new start -> all outputs at reset values during rst; second frame writes from word_idx 0 correctly.
